// File: rtl/gfx_mem_arbiter.sv
// Shares one single-port synchronous memory bank between four read clients and one write client.
// One grant per cycle; the winner sees ready and read data on the following cycle.
module gfx_mem_arbiter #(
    parameter int ADDRESS_BITS = 16,
    parameter int BITS         = 16,
    parameter int ROUND_ROBIN  = 1
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [ADDRESS_BITS-1:0] spcon_memory_address,
    output logic [BITS-1:0]         spcon_memory_data,
    input  logic                    spcon_rvalid,
    output logic                    spcon_rready,
    input  logic [ADDRESS_BITS-1:0] bg0_memory_address,
    output logic [BITS-1:0]         bg0_memory_data,
    input  logic                    bg0_rvalid,
    output logic                    bg0_rready,
    input  logic [ADDRESS_BITS-1:0] bg1_memory_address,
    output logic [BITS-1:0]         bg1_memory_data,
    input  logic                    bg1_rvalid,
    output logic                    bg1_rready,
    input  logic [ADDRESS_BITS-1:0] ov_memory_address,
    output logic [BITS-1:0]         ov_memory_data,
    input  logic                    ov_rvalid,
    output logic                    ov_rready,
    input  logic [ADDRESS_BITS-1:0] fl_memory_address,
    input  logic [BITS-1:0]         fl_memory_data,
    input  logic                    fl_wvalid,
    output logic                    fl_wready,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [BITS-1:0]         mem_wdata,
    output logic                    mem_wr,
    input  logic [BITS-1:0]         mem_rdata,
    output logic [2:0]              grant_id
);

    localparam int NCLI = 5;
    localparam logic [2:0] FL_ID = 3'd4;

    logic            r_resp_valid;
    logic [2:0]      r_resp_id;
    logic [2:0]      r_ptr;

    logic [NCLI-1:0] w_req;
    logic [NCLI-1:0] w_rsp;
    logic [NCLI-1:0] w_elig;
    logic [2:0]      w_start;
    logic            w_gnt_vld;
    logic [2:0]      w_gnt_id;

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    assign w_req = {fl_wvalid, ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};

    // Response slot is suppressed while reset is held so a pending ready is dropped.
    always_comb begin
        w_rsp = '0;
        for (int i = 0; i < NCLI; i++)
            w_rsp[i] = r_resp_valid && RSTb && (r_resp_id == 3'(i));
    end

    assign w_elig  = w_req & ~w_rsp & {NCLI{RSTb}};
    assign w_start = (ROUND_ROBIN != 0) ? r_ptr : 3'd0;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 3'd0;
        for (int k = 0; k < NCLI; k++) begin
            if (!w_gnt_vld && w_elig[wrap5({1'b0, w_start} + 4'(k))]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = wrap5({1'b0, w_start} + 4'(k));
            end
        end
    end

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_wr      = 1'b0;
        if (w_gnt_vld) begin
            case (w_gnt_id)
                3'd0:    mem_address = spcon_memory_address;
                3'd1:    mem_address = bg0_memory_address;
                3'd2:    mem_address = bg1_memory_address;
                3'd3:    mem_address = ov_memory_address;
                default: begin
                    mem_address = fl_memory_address;
                    mem_wdata   = fl_memory_data;
                    mem_wr      = 1'b1;
                end
            endcase
        end
    end

    assign grant_id = w_gnt_vld ? w_gnt_id : 3'd7;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 3'd0;
            r_ptr        <= 3'd0;
        end else begin
            r_resp_valid <= w_gnt_vld;
            r_resp_id    <= w_gnt_id;
            if ((ROUND_ROBIN != 0) && w_gnt_vld)
                r_ptr <= (w_gnt_id == FL_ID) ? 3'd0 : w_gnt_id + 3'd1;
        end
    end

    assign spcon_rready      = w_rsp[0];
    assign bg0_rready        = w_rsp[1];
    assign bg1_rready        = w_rsp[2];
    assign ov_rready         = w_rsp[3];
    assign fl_wready         = w_rsp[4];

    assign spcon_memory_data = w_rsp[0] ? mem_rdata : '0;
    assign bg0_memory_data   = w_rsp[1] ? mem_rdata : '0;
    assign bg1_memory_data   = w_rsp[2] ? mem_rdata : '0;
    assign ov_memory_data    = w_rsp[3] ? mem_rdata : '0;

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter: round-robin instance plus a fixed-priority instance,
// each backed by a read-first synchronous memory model.
module tb_gfx_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    always #5 CLK = ~CLK;

    // round-robin DUT signals
    logic [15:0] sp_a, b0_a, b1_a, ov_a, fl_a, fl_d;
    logic        sp_v, b0_v, b1_v, ov_v, fl_v;
    logic [15:0] sp_d, b0_d, b1_d, ov_d;
    logic        sp_r, b0_r, b1_r, ov_r, fl_r;
    logic [15:0] m_a, m_wd, m_rd;
    logic        m_wr;
    logic [2:0]  gid;

    // fixed-priority DUT signals
    logic [15:0] f_sp_a, f_b0_a, f_b1_a, f_ov_a, f_fl_a, f_fl_d;
    logic        f_sp_v, f_b0_v, f_b1_v, f_ov_v, f_fl_v;
    logic [15:0] f_sp_d, f_b0_d, f_b1_d, f_ov_d;
    logic        f_sp_r, f_b0_r, f_b1_r, f_ov_r, f_fl_r;
    logic [15:0] f_m_a, f_m_wd, f_m_rd;
    logic        f_m_wr;
    logic [2:0]  f_gid;

    logic [15:0] mem   [0:65535];
    logic [15:0] f_mem [0:65535];

    int n_vec = 0;
    int n_err = 0;

    gfx_mem_arbiter #(.ADDRESS_BITS(16), .BITS(16), .ROUND_ROBIN(1)) u_dut (
        .CLK(CLK), .RSTb(RSTb),
        .spcon_memory_address(sp_a), .spcon_memory_data(sp_d), .spcon_rvalid(sp_v), .spcon_rready(sp_r),
        .bg0_memory_address(b0_a), .bg0_memory_data(b0_d), .bg0_rvalid(b0_v), .bg0_rready(b0_r),
        .bg1_memory_address(b1_a), .bg1_memory_data(b1_d), .bg1_rvalid(b1_v), .bg1_rready(b1_r),
        .ov_memory_address(ov_a), .ov_memory_data(ov_d), .ov_rvalid(ov_v), .ov_rready(ov_r),
        .fl_memory_address(fl_a), .fl_memory_data(fl_d), .fl_wvalid(fl_v), .fl_wready(fl_r),
        .mem_address(m_a), .mem_wdata(m_wd), .mem_wr(m_wr), .mem_rdata(m_rd), .grant_id(gid)
    );

    gfx_mem_arbiter #(.ADDRESS_BITS(16), .BITS(16), .ROUND_ROBIN(0)) u_fp (
        .CLK(CLK), .RSTb(RSTb),
        .spcon_memory_address(f_sp_a), .spcon_memory_data(f_sp_d), .spcon_rvalid(f_sp_v), .spcon_rready(f_sp_r),
        .bg0_memory_address(f_b0_a), .bg0_memory_data(f_b0_d), .bg0_rvalid(f_b0_v), .bg0_rready(f_b0_r),
        .bg1_memory_address(f_b1_a), .bg1_memory_data(f_b1_d), .bg1_rvalid(f_b1_v), .bg1_rready(f_b1_r),
        .ov_memory_address(f_ov_a), .ov_memory_data(f_ov_d), .ov_rvalid(f_ov_v), .ov_rready(f_ov_r),
        .fl_memory_address(f_fl_a), .fl_memory_data(f_fl_d), .fl_wvalid(f_fl_v), .fl_wready(f_fl_r),
        .mem_address(f_m_a), .mem_wdata(f_m_wd), .mem_wr(f_m_wr), .mem_rdata(f_m_rd), .grant_id(f_gid)
    );

    always @(posedge CLK) begin
        if (m_wr) mem[m_a] <= m_wd;
        m_rd <= mem[m_a];
        if (f_m_wr) f_mem[f_m_a] <= f_m_wd;
        f_m_rd <= f_mem[f_m_a];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance to the next negedge; inputs are driven here and outputs sampled 1 time unit later
    task automatic step();
        @(negedge CLK);
    endtask

    function automatic logic [4:0] rdy_vec();
        return {fl_r, ov_r, b1_r, b0_r, sp_r};
    endfunction

    int cnt [5];
    int idle;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 16'h0;
            f_mem[i] = 16'h0;
        end
        mem[16'h0010]   = 16'h1111;
        mem[16'h0123]   = 16'hBEEF;
        f_mem[16'h0010] = 16'hAAAA;
        f_mem[16'h0030] = 16'h3333;
        {sp_v, b0_v, b1_v, ov_v, fl_v} = '0;
        {f_sp_v, f_b0_v, f_b1_v, f_ov_v, f_fl_v} = '0;
        sp_a = 16'h0010; b0_a = 16'h0101; b1_a = 16'h0102; ov_a = 16'h0103;
        fl_a = 16'h0200; fl_d = 16'hC0DE;
        f_sp_a = 16'h0010; f_b0_a = 16'h0; f_b1_a = 16'h0; f_ov_a = 16'h0030;
        f_fl_a = 16'h0300; f_fl_d = 16'h7777;

        // reset held with every client requesting
        for (int c = 0; c < 3; c++) begin
            step();
            {sp_v, b0_v, b1_v, ov_v, fl_v} = '1;
            #1;
            chk("rst_ready", 32'(rdy_vec()), 32'h0);
            chk("rst_memwr", 32'(m_wr), 32'h0);
            chk("rst_gid", 32'(gid), 32'd7);
        end
        step(); RSTb = 1'b1; #1;
        chk("rel_gid", 32'(gid), 32'd0);
        chk("rel_addr", 32'(m_a), 32'h0010);
        step(); {sp_v, b0_v, b1_v, ov_v, fl_v} = '0; #1;
        chk("rel_ready", 32'(rdy_vec()), 32'h01);
        chk("rel_data", 32'(sp_d), 32'h1111);
        chk("idle_gid", 32'(gid), 32'd7);

        // single read by bg0
        step(); b0_a = 16'h0123; b0_v = 1'b1; #1;
        chk("rd_addr", 32'(m_a), 32'h0123);
        chk("rd_gid", 32'(gid), 32'd1);
        step(); b0_v = 1'b0; #1;
        chk("rd_ready", 32'(rdy_vec()), 32'h02);
        chk("rd_data", 32'(b0_d), 32'hBEEF);
        chk("rd_others", {sp_d, b1_d} | 32'(ov_d), 32'h0);

        // flash write, then overlay reads it back
        step(); fl_a = 16'h0040; fl_d = 16'h5A5A; fl_v = 1'b1; #1;
        chk("wr_gid", 32'(gid), 32'd4);
        chk("wr_en", 32'(m_wr), 32'h1);
        chk("wr_bus", {m_a, m_wd}, {16'h0040, 16'h5A5A});
        step(); fl_v = 1'b0; ov_a = 16'h0040; ov_v = 1'b1; #1;
        chk("wr_ready", 32'(rdy_vec()), 32'h10);
        chk("wr_rd_gid", 32'(gid), 32'd3);
        chk("wr_rd_memwr", 32'(m_wr), 32'h0);
        step(); ov_v = 1'b0; #1;
        chk("wr_rd_ready", 32'(rdy_vec()), 32'h08);
        chk("wr_rd_data", 32'(ov_d), 32'h5A5A);

        // round-robin fairness from a freshly reset pointer
        step(); RSTb = 1'b0; #1;
        chk("rst2_gid", 32'(gid), 32'd7);
        ov_a = 16'h0103; fl_a = 16'h0200; fl_d = 16'hC0DE;
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        idle = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            RSTb = 1'b1;
            {sp_v, b0_v, b1_v, ov_v, fl_v} = '1;
            #1;
            chk("rr_gid", 32'(gid), 32'(k % 5));
            if (k > 0) chk("rr_ready", 32'(rdy_vec()), 32'(5'b1 << ((k - 1) % 5)));
            if (gid < 3'd5) cnt[gid]++; else idle++;
        end
        step(); {sp_v, b0_v, b1_v, ov_v, fl_v} = '0; #1;
        chk("rr_last_ready", 32'(rdy_vec()), 32'h10);
        for (int i = 0; i < 5; i++) chk("rr_count", 32'(cnt[i]), 32'd4);
        chk("rr_idle", 32'(idle), 32'd0);

        // reset lands in the response cycle of a spcon grant
        step(); sp_a = 16'h0010; sp_v = 1'b1; #1;
        chk("mr_gid", 32'(gid), 32'd0);
        step(); RSTb = 1'b0; #1;
        chk("mr_ready_rst", 32'(sp_r), 32'h0);
        chk("mr_gid_rst", 32'(gid), 32'd7);
        step(); RSTb = 1'b1; #1;
        chk("mr_ready_rel", 32'(sp_r), 32'h0);
        chk("mr_regrant", 32'(gid), 32'd0);
        step(); sp_v = 1'b0; #1;
        chk("mr_ready", 32'(rdy_vec()), 32'h01);
        chk("mr_data", 32'(sp_d), 32'h1111);

        // fixed priority: spcon and ov alternate, fl never wins
        for (int k = 0; k < 8; k++) begin
            step();
            {f_sp_v, f_ov_v, f_fl_v} = 3'b111;
            #1;
            chk("fp_gid", 32'(f_gid), (k % 2 == 0) ? 32'd0 : 32'd3);
            chk("fp_fl_ready", 32'(f_fl_r), 32'h0);
            if (k > 0 && (k % 2 == 0)) chk("fp_ov_data", {15'h0, f_ov_r, f_ov_d}, {15'h0, 1'b1, 16'h3333});
            if (k % 2 == 1) chk("fp_sp_data", {15'h0, f_sp_r, f_sp_d}, {15'h0, 1'b1, 16'hAAAA});
        end
        step(); {f_sp_v, f_ov_v} = 2'b00; #1;
        chk("fp_fl_after", 32'(f_gid), 32'd4);
        f_fl_v = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
